serial_word_receiver: RTL
=========================

SERIAL_WORD_RECEIVER -- requirements
Module: serial_word_receiver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data word width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port ser_in, input, 1 bit: the serial line, idle high.
REQ-005 The block SHALL have port bit_en, input, 1 bit: bit strobe; ser_in SHALL be sampled only on edges where bit_en=1.
REQ-006 The block SHALL have port lsb_first, input, 1 bit: bit order; 0 = MSB-first, 1 = LSB-first.
REQ-007 The block SHALL have port data_ack, input, 1 bit: the consumer accepts data_out.
REQ-008 The block SHALL have port data_out, output, WIDTH bits: the last good received word.
REQ-009 The block SHALL have port data_valid, output, 1 bit: data_out holds an unaccepted word.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse, stop bit sampled low.
REQ-011 The block SHALL have port overrun, output, 1 bit: one-cycle pulse, unaccepted word overwritten.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 Frame format SHALL be: start bit 0, then WIDTH data bits, then stop bit 1, with each bit qualified by bit_en.
REQ-014 The FSM SHALL have exactly four states: IDLE, DATA, STOP and BREAK.
REQ-015 In IDLE, bit_en=1 with ser_in=0 SHALL move to DATA, clear the bit counter, clear the shift register and latch lsb_first; ser_in=1 SHALL stay in IDLE.
REQ-016 In DATA, each bit_en=1 edge SHALL shift one bit: MSB-first shreg <= {shreg[WIDTH-2:0], ser_in}; LSB-first shreg <= {ser_in, shreg[WIDTH-1:1]}.
REQ-017 In DATA, the bit counter SHALL increment per sampled bit, and the edge sampling bit WIDTH-1 SHALL move to STOP.
REQ-018 Changes on lsb_first after the start bit SHALL have no effect until the next frame.
REQ-019 In STOP with bit_en=1 and ser_in=1, the block SHALL load data_out <= shreg, set data_valid and return to IDLE.
REQ-020 In STOP with bit_en=1 and ser_in=0, the block SHALL pulse frame_err, leave data_out and data_valid unchanged and move to BREAK.
REQ-021 BREAK SHALL stay until an edge with bit_en=1 and ser_in=1, then move to IDLE; a low line SHALL NOT restart a frame while in BREAK.
REQ-022 In any state, edges with bit_en=0 SHALL hold the state, counter and shift register.
REQ-023 data_valid SHALL clear on an edge where data_ack=1 and no new word loads.
REQ-024 If a word loads while data_valid=1 and data_ack=0, the new word SHALL overwrite data_out, data_valid SHALL stay 1 and overrun SHALL pulse.
REQ-025 If a word loads with data_ack=1 on the same edge, the new word SHALL load, data_valid SHALL stay 1 and overrun SHALL stay 0.
REQ-026 data_ack while data_valid=0 SHALL be ignored.
REQ-027 Latency SHALL be: data_valid rises on the edge after the one that samples the stop bit, i.e. it is registered.
REQ-028 frame_err and overrun SHALL be registered, one clock wide, and mutually exclusive by construction.

Reset
REQ-029 rst=1 on a rising edge SHALL force: state IDLE, counter 0, shreg 0, data_out 0, data_valid 0, frame_err 0, overrun 0, busy 0.
REQ-030 rst SHALL override all other inputs.
REQ-031 Reset mid-frame SHALL abandon the partial word with no error pulse, and the first frame SHALL begin at the first start bit after rst deasserts.

Structure
REQ-032 The shared package/include SHALL hold the FSM state encodings (2-bit constants for IDLE, DATA, STOP, BREAK) and the default WIDTH.
REQ-033 The design SHALL have one sub-module, deser_shift_reg (WIDTH-wide: clear, hold, shift-left-in, shift-right-in), selected by the FSM.
REQ-034 The bit counter and output register SHALL stay in the top module.

Verification (WIDTH=4, bit_en=1 unless stated)
REQ-035 The bench SHALL cover: lsb_first=0, ser_in 0,1,0,1,1,1 -> data_out=1011, data_valid=1 one edge after the stop bit, busy low after.
REQ-036 The bench SHALL cover: lsb_first=1, ser_in 0,1,1,0,1,1 -> data_out=1011.
REQ-037 The bench SHALL cover: frame 0,1,1,1,1,0 (bad stop) -> frame_err one-cycle pulse, data_out unchanged, state BREAK until ser_in=1, and an extra 0 in BREAK starts no frame.
REQ-038 The bench SHALL cover: two good frames 1011 then 0110 with data_ack=0 -> overrun pulse, data_out=0110, data_valid=1; a repeat with data_ack=1 on the load edge -> no overrun.
REQ-039 The bench SHALL cover: bit_en toggling 1,0,0,1 per bit during frame 1011 -> same result as the continuous case, counter held during gaps.
REQ-040 The bench SHALL cover: rst=1 after two data bits, then a full frame 0,0,1,1,0,1 -> all outputs 0 during reset, then data_out=0110 with no frame_err.

Source files
------------

// File: rtl/serial_word_receiver_pkg.sv
// Shared types for the serial word receiver: FSM state encodings, shift-register
// operations and the default data width.
package serial_word_receiver_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DATA  = 2'b01,
      STOP  = 2'b10,
      BREAK = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      SH_HOLD  = 2'b00,
      SH_CLEAR = 2'b01,
      SH_LEFT  = 2'b10,
      SH_RIGHT = 2'b11
   } shift_op_e;

endpackage

// File: rtl/deser_shift_reg.sv
// WIDTH-wide deserialising shift register: clear, hold, shift-left-in or shift-right-in.
// Single-cycle update; no flow control, the owning FSM selects the operation.
module deser_shift_reg
   import serial_word_receiver_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  shift_op_e        op_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] shreg_o
);

   logic [WIDTH-1:0] shreg_q, shreg_d;

   always_comb begin
      shreg_d = shreg_q;
      case (op_i)
         SH_CLEAR: shreg_d = '0;
         SH_LEFT:  shreg_d = {shreg_q[WIDTH-2:0], bit_i};
         SH_RIGHT: shreg_d = {bit_i, shreg_q[WIDTH-1:1]};
         default:  shreg_d = shreg_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) shreg_q <= '0;
      else     shreg_q <= shreg_d;
   end

   assign shreg_o = shreg_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Receives start/WIDTH data/stop frames strobed by bit_en into a one-deep output register.
// data_valid is registered off the stop-bit edge; an unacked word is overwritten with an overrun pulse.
module serial_word_receiver
   import serial_word_receiver_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ser_in,
   input  logic             bit_en,
   input  logic             lsb_first,
   input  logic             data_ack,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             lsb_q, lsb_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             data_valid_q, data_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
   shift_op_e        sh_op;
   logic [WIDTH-1:0] shreg;
   logic             load;

   deser_shift_reg #(.WIDTH(WIDTH)) u_shreg (
      .clk     (clk),
      .rst     (rst),
      .op_i    (sh_op),
      .bit_i   (ser_in),
      .shreg_o (shreg)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lsb_d       = lsb_q;
      sh_op       = SH_HOLD;
      load        = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bit_en && !ser_in) begin
               state_d = DATA;
               cnt_d   = '0;
               lsb_d   = lsb_first;
               sh_op   = SH_CLEAR;
            end
         end
         DATA: begin
            if (bit_en) begin
               sh_op = lsb_q ? SH_RIGHT : SH_LEFT;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_BIT) begin
                  state_d = STOP;
                  cnt_d   = '0;
               end
            end
         end
         STOP: begin
            if (bit_en) begin
               if (ser_in) begin
                  load    = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
            end
         end
         BREAK: begin
            // Only a high line releases a break; a low line here is never a start bit.
            if (bit_en && ser_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      data_out_d   = load ? shreg : data_out_q;
      data_valid_d = load ? 1'b1 : (data_valid_q && !data_ack);
      overrun_d    = load && data_valid_q && !data_ack;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         lsb_q        <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lsb_q        <= lsb_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != IDLE);

endmodule
